// File: rtl/branch_predict_resolver.sv
// branch_predict_resolver
// Decode-stage branch resolution with a 2-bit bimodal predictor.
// Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR in ID using forwarded
// operands, raises a load-use stall, and issues a same-cycle fetch redirect
// on jumps and on conditional-branch mispredictions. The cycle after a
// redirect the ID instruction is squashed (it is a wrong-path fetch).
// Optional build macro: BRANCH_STATS_EN adds br_count / mispred_count.

module branch_predict_resolver #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_instr,
    input  logic            id_pred_taken,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wr,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_wr,
    input  logic [XLEN-1:0] mem_result,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
`endif
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    assign imm_b = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25],
                    id_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){id_instr[31]}}, id_instr[19:12], id_instr[20],
                    id_instr[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};

    logic            is_cond;
    logic            is_jal;
    logic            is_jalr;
    logic [XLEN-1:0] imm;

    // Classify the decode instruction and pick its immediate
    always_comb begin
        is_cond = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        imm     = '0;
        case (opcode)
            OP_BRANCH: begin
                imm = imm_b;
                case (funct3)
                    3'b000, 3'b001, 3'b100,
                    3'b101, 3'b110, 3'b111: is_cond = 1'b1;
                    default:                is_cond = 1'b0;
                endcase
            end
            OP_JAL: begin
                is_jal = 1'b1;
                imm    = imm_j;
            end
            OP_JALR: begin
                is_jalr = 1'b1;
                imm     = imm_i;
            end
            default: begin
                is_cond = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand forwarding: EX beats MEM beats register file, x0 never
    // forwarded
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // Forward rs1 from the youngest in-flight producer
    always_comb begin
        op1 = rf_rs1;
        if (ex_wr && (ex_rd == rs1) && (rs1 != 5'd0)) begin
            op1 = ex_result;
        end else if (mem_wr && (mem_rd == rs1) && (rs1 != 5'd0)) begin
            op1 = mem_result;
        end
    end

    // Forward rs2 from the youngest in-flight producer
    always_comb begin
        op2 = rf_rs2;
        if (ex_wr && (ex_rd == rs2) && (rs2 != 5'd0)) begin
            op2 = ex_result;
        end else if (mem_wr && (mem_rd == rs2) && (rs2 != 5'd0)) begin
            op2 = mem_result;
        end
    end

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    logic op_eq;
    logic op_lt_s;
    logic op_lt_u;
    logic br_taken;

    assign op_eq   = (op1 == op2);
    assign op_lt_s = ($signed(op1) < $signed(op2));
    assign op_lt_u = (op1 < op2);

    // Evaluate the conditional-branch outcome from funct3
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = op_eq;
            3'b001:  br_taken = !op_eq;
            3'b100:  br_taken = op_lt_s;
            3'b101:  br_taken = !op_lt_s;
            3'b110:  br_taken = op_lt_u;
            3'b111:  br_taken = !op_lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard, resolution and redirect
    // ------------------------------------------------------------------
    logic            squash_q;
    logic            dec_valid;
    logic            load_hit;
    logic            resolve;
    logic            cond_resolved;
    logic            cond_mispred;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] fall_through;

    // A squashed slot holds a wrong-path fetch and must have no effect.
    assign dec_valid = id_valid && !squash_q;

    // JAL needs no register operand, so only branches and JALR can stall.
    assign load_hit = ex_is_load && ex_wr && (ex_rd != 5'd0) &&
                      ((ex_rd == rs1) || (is_cond && (ex_rd == rs2)));
    assign stall    = dec_valid && (is_cond || is_jalr) && load_hit;

    assign resolve       = dec_valid && !stall;
    assign cond_resolved = resolve && is_cond;
    assign cond_mispred  = cond_resolved && (br_taken != id_pred_taken);
    assign redirect      = (resolve && (is_jal || is_jalr)) || cond_mispred;

    assign br_target    = id_pc + imm;
    assign jalr_sum     = op1 + imm;
    assign jalr_target  = {jalr_sum[XLEN-1:1], 1'b0};
    assign fall_through = id_pc + PC_STEP;

    // Select the corrected fetch address; zero whenever no redirect
    always_comb begin
        redirect_pc = '0;
        if (redirect) begin
            if (is_jalr) begin
                redirect_pc = jalr_target;
            end else if (is_jal || br_taken) begin
                redirect_pc = br_target;
            end else begin
                redirect_pc = fall_through;
            end
        end
    end

    // Mark the instruction following a redirect as wrong-path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_q <= 1'b0;
        end else begin
            squash_q <= redirect;
        end
    end

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;

    assign rd_idx  = if_pc[IDX_W+1:2];
    assign upd_idx = id_pc[IDX_W+1:2];

    // The read is straight from the array, so a same-index update in this
    // cycle is only seen by lookups from the next cycle on.
    assign pred_taken = bht[rd_idx][1];

    // Train the saturating counters on every resolved conditional branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (cond_resolved) begin
            if (br_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end
            end else begin
                if (bht[upd_idx] != 2'b00) begin
                    bht[upd_idx] <= bht[upd_idx] - 2'b01;
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Count resolved conditional branches and their mispredictions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            if (cond_resolved) begin
                br_count <= br_count + 32'd1;
            end
            if (cond_mispred) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end
`endif

    // Fetch PC bits outside the index field and the dropped JALR bit 0
    // carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_branch_predict_resolver.sv
// Bench for branch_predict_resolver: directed scenarios followed by a
// randomized run, all checked against a behavioural predictor model.
module tb_branch_predict_resolver;

    localparam int XLEN = 32;
    localparam int ENT  = 64;

    localparam int K_NONE = 0;
    localparam int K_COND = 1;
    localparam int K_JAL  = 2;
    localparam int K_JALR = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic            id_pred_taken;
    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    logic [4:0]      ex_rd;
    logic            ex_wr;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_result;
    logic [4:0]      mem_rd;
    logic            mem_wr;
    logic [XLEN-1:0] mem_result;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0]     br_count;
    logic [31:0]     mispred_count;
`endif

    branch_predict_resolver #(.XLEN(XLEN), .BHT_ENTRIES(ENT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_pred_taken (id_pred_taken),
        .rf_rs1        (rf_rs1),
        .rf_rs2        (rf_rs2),
        .ex_rd         (ex_rd),
        .ex_wr         (ex_wr),
        .ex_is_load    (ex_is_load),
        .ex_result     (ex_result),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_result    (mem_result),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int  bht_m [ENT];
    bit  squash_m;
    int  br_m;
    int  mis_m;

    // Description of the instruction currently presented in decode
    int cur_kind, cur_f3, cur_rs1, cur_rs2, cur_imm;

    // Model outputs for the current cycle
    bit          e_stall, e_redirect, e_pred, e_upd, e_taken;
    logic [31:0] e_rpc;
    int          upd_idx;

    int         f3_tab [6] = '{0, 1, 4, 5, 6, 7};
    logic [6:0] op_tab [4] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input int f3, input int r1, input int r2, input int imm);
        logic [12:0] i;
        i = 13'(imm);
        return {i[12], i[10:5], 5'(r2), 5'(r1), 3'(f3), i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input int rd, input int imm);
        logic [20:0] i;
        i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input int rd, input int r1, input int imm);
        return {12'(imm), 5'(r1), 3'b000, 5'(rd), 7'b1100111};
    endfunction

    function automatic logic [31:0] fwd(input int rs, input logic [31:0] rf);
        if (rs != 0 && ex_wr && int'(ex_rd) == rs) return ex_result;
        if (rs != 0 && mem_wr && int'(mem_rd) == rs) return mem_result;
        return rf;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) bht_m[i] = 1;
        squash_m = 1'b0;
        br_m     = 0;
        mis_m    = 0;
    endtask

    // Compute the expected outputs from the instruction semantics.
    task automatic predict();
        bit          valid, needs_regs, hazard;
        logic [31:0] a, b;
        valid      = id_valid && !squash_m;
        needs_regs = (cur_kind == K_COND) || (cur_kind == K_JALR);
        hazard     = ex_is_load && ex_wr && (ex_rd != 5'd0) &&
                     ((needs_regs && int'(ex_rd) == cur_rs1) ||
                      (cur_kind == K_COND && int'(ex_rd) == cur_rs2));
        e_stall = valid && needs_regs && hazard;
        a = fwd(cur_rs1, rf_rs1);
        b = fwd(cur_rs2, rf_rs2);
        case (cur_f3)
            0:       e_taken = (a == b);
            1:       e_taken = (a != b);
            4:       e_taken = (int'(a) < int'(b));
            5:       e_taken = (int'(a) >= int'(b));
            6:       e_taken = (a < b);
            default: e_taken = (a >= b);
        endcase
        e_redirect = 1'b0;
        e_rpc      = 32'd0;
        e_upd      = 1'b0;
        if (valid && !e_stall) begin
            case (cur_kind)
                K_JAL: begin
                    e_redirect = 1'b1;
                    e_rpc      = id_pc + 32'(cur_imm);
                end
                K_JALR: begin
                    e_redirect = 1'b1;
                    e_rpc      = (a + 32'(cur_imm)) & 32'hFFFF_FFFE;
                end
                K_COND: begin
                    e_upd = 1'b1;
                    if (e_taken != id_pred_taken) begin
                        e_redirect = 1'b1;
                        e_rpc      = e_taken ? (id_pc + 32'(cur_imm)) : (id_pc + 32'd4);
                    end
                end
                default: e_upd = 1'b0;
            endcase
        end
        upd_idx = int'((id_pc / 32'd4) % 32'(ENT));
        e_pred  = rst_n && (bht_m[int'((if_pc / 32'd4) % 32'(ENT))] >= 2);
    endtask

    task automatic commit();
        if (e_upd) begin
            if (e_taken) bht_m[upd_idx] = (bht_m[upd_idx] >= 3) ? 3 : bht_m[upd_idx] + 1;
            else         bht_m[upd_idx] = (bht_m[upd_idx] <= 0) ? 0 : bht_m[upd_idx] - 1;
            br_m++;
            if (e_redirect) mis_m++;
        end
        squash_m = e_redirect;
    endtask

    // Inputs are already driven (at a falling edge); check then clock once.
    task automatic step(input string tag);
        predict();
        #1;
        check({tag, ".pred"},     32'(pred_taken), 32'(e_pred));
        check({tag, ".stall"},    32'(stall),      32'(e_stall));
        check({tag, ".redirect"}, 32'(redirect),   32'(e_redirect));
        check({tag, ".rpc"},      redirect_pc,     e_rpc);
        @(posedge clk);
        if (rst_n) commit();
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        id_pc         = '0;
        id_instr      = '0;
        id_pred_taken = 1'b0;
        rf_rs1        = '0;
        rf_rs2        = '0;
        ex_rd         = '0;
        ex_wr         = 1'b0;
        ex_is_load    = 1'b0;
        ex_result     = '0;
        mem_rd        = '0;
        mem_wr        = 1'b0;
        mem_result    = '0;
        cur_kind      = K_NONE;
        cur_f3        = 0;
        cur_rs1       = 0;
        cur_rs2       = 0;
        cur_imm       = 0;
    endtask

    task automatic set_cond(input int f3, input int r1, input int r2, input int imm);
        cur_kind = K_COND; cur_f3 = f3; cur_rs1 = r1; cur_rs2 = r2; cur_imm = imm;
        id_instr = enc_b(f3, r1, r2, imm);
        id_valid = 1'b1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'd5;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        int          sel, r1, r2;
        logic [31:0] tmp;
        idle();
        sel = int'($urandom_range(0, 9));
        r1  = int'($urandom_range(0, 4));
        r2  = int'($urandom_range(0, 4));
        id_valid      = ($urandom_range(0, 3) != 0);
        id_pc         = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 15) == 0) id_pc = 32'hFFFF_FFF8;
        if_pc         = ($urandom_range(0, 3) == 0) ? id_pc
                                                    : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        id_pred_taken = 1'($urandom_range(0, 1));
        rf_rs1        = pick_val();
        rf_rs2        = pick_val();
        ex_rd         = 5'($urandom_range(0, 4));
        ex_wr         = 1'($urandom_range(0, 1));
        ex_is_load    = ($urandom_range(0, 2) == 0);
        ex_result     = pick_val();
        mem_rd        = 5'($urandom_range(0, 4));
        mem_wr        = 1'($urandom_range(0, 1));
        mem_result    = pick_val();
        if (sel <= 5) begin
            set_cond(f3_tab[sel], r1, r2, (int'($urandom_range(0, 63)) - 32) * 2);
            id_valid = ($urandom_range(0, 3) != 0);
        end else if (sel == 6) begin
            cur_kind = K_JAL;
            cur_imm  = (int'($urandom_range(0, 1023)) - 512) * 2;
            id_instr = enc_jal(int'($urandom_range(0, 31)), cur_imm);
        end else if (sel == 7) begin
            cur_kind = K_JALR;
            cur_rs1  = r1;
            cur_imm  = int'($urandom_range(0, 63)) - 32;
            id_instr = enc_jalr(int'($urandom_range(0, 31)), r1, cur_imm);
        end else if (sel == 8) begin
            id_instr = enc_b(2 + int'($urandom_range(0, 1)), r1, r2, 16);
        end else begin
            tmp      = $urandom;
            id_instr = {tmp[31:7], op_tab[$urandom_range(0, 3)]};
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        idle();
        if_pc = 32'h40;
        model_reset();
        @(negedge clk);
        step("reset");

        // BEQ mispredicted not-taken, then the squashed follower
        @(negedge clk);
        rst_n = 1'b1;
        id_pc = 32'h100; rf_rs1 = 32'd5; rf_rs2 = 32'd5;
        set_cond(0, 1, 2, 16);
        step("beq_redirect");
        check("beq_target", redirect_pc, 32'h110);
        @(negedge clk);
        step("beq_squashed");

        // Train PC 0x40 taken three times; lookup at the same index sees
        // the pre-update counter each time
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            if_pc = 32'h40; id_pc = 32'h40; id_pred_taken = 1'b1;
            rf_rs1 = 32'd9; rf_rs2 = 32'd9;
            set_cond(0, 1, 2, 8);
            step("train40");
        end
        @(negedge clk);
        idle();
        if_pc = 32'h40;
        step("pred40");
        check("pred40_strong", 32'(pred_taken), 32'd1);

        // Load-use stall on BNE x3,x0, then forwarded from MEM
        @(negedge clk);
        idle();
        id_pc = 32'h200; rf_rs1 = 32'd7;
        ex_rd = 5'd3; ex_wr = 1'b1; ex_is_load = 1'b1; ex_result = 32'hDEAD;
        set_cond(1, 3, 0, 12);
        step("loaduse_stall");
        @(negedge clk);
        ex_rd = 5'd0; ex_wr = 1'b0; ex_is_load = 1'b0;
        mem_rd = 5'd3; mem_wr = 1'b1; mem_result = 32'd0;
        step("loaduse_resolve");

        // Signed versus unsigned less-than
        @(negedge clk);
        idle();
        id_pc = 32'h300; rf_rs1 = 32'hFFFF_FFFF; rf_rs2 = 32'd1;
        set_cond(4, 1, 2, -32);
        step("blt_signed");
        @(negedge clk);
        idle();
        step("blt_squash");
        @(negedge clk);
        id_pc = 32'h300; rf_rs1 = 32'hFFFF_FFFF; rf_rs2 = 32'd1; id_pred_taken = 1'b1;
        set_cond(6, 1, 2, -32);
        step("bltu_unsigned");
        check("bltu_fallthrough", redirect_pc, 32'h304);
        @(negedge clk);
        idle();
        step("bltu_squash");

        // JALR with EX-forwarded base, bit 0 cleared
        @(negedge clk);
        id_pc = 32'h400; rf_rs1 = 32'h203;
        ex_rd = 5'd5; ex_wr = 1'b1; ex_result = 32'h305;
        cur_kind = K_JALR; cur_rs1 = 5; cur_imm = 0;
        id_instr = enc_jalr(1, 5, 0); id_valid = 1'b1;
        step("jalr_fwd");
        check("jalr_target", redirect_pc, 32'h304);

        // Reset while a squash is pending discards it
        @(negedge clk);
        idle();
        if_pc = 32'h40;
        cur_kind = K_JAL; cur_imm = 64;
        id_pc = 32'h500; id_instr = enc_jal(1, 64); id_valid = 1'b1;
        step("jal_before_rst");
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        model_reset();
        step("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cur_kind = K_JAL; cur_imm = -8;
        id_pc = 32'h600; id_instr = enc_jal(0, -8); id_valid = 1'b1;
        step("jal_after_rst");
        @(negedge clk);
        idle();
        step("jal_squash");

        // Four conditional branches, the last one mispredicted
        @(negedge clk);
        id_pc = 32'h700; rf_rs1 = 32'd5; rf_rs2 = 32'd5; id_pred_taken = 1'b1;
        set_cond(0, 1, 2, 16);
        step("stat_beq");
        @(negedge clk);
        id_pred_taken = 1'b0;
        set_cond(1, 1, 2, 16);
        step("stat_bne");
        @(negedge clk);
        rf_rs1 = 32'd1; rf_rs2 = 32'd2; id_pred_taken = 1'b1;
        set_cond(4, 1, 2, 16);
        step("stat_blt");
        @(negedge clk);
        rf_rs1 = 32'd5; rf_rs2 = 32'd5; id_pred_taken = 1'b0;
        set_cond(5, 1, 2, 16);
        step("stat_bge_mispred");
        @(negedge clk);
        idle();
        step("stat_squash");
`ifdef BRANCH_STATS_EN
        check("br_count4", br_count, 32'd4);
        check("mispred_count1", mispred_count, 32'd1);
`endif

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rand_inputs();
            step("rand");
        end
`ifdef BRANCH_STATS_EN
        #1;
        check("br_count_rand", br_count, 32'(br_m));
        check("mispred_count_rand", mispred_count, 32'(mis_m));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolver.md
BRANCH_PREDICT_RESOLVER -- requirements
Module: branch_predict_resolver

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width.
REQ-002 The block SHALL have parameter BHT_ENTRIES, default 64, giving the number of 2-bit predictor counters; it must be a power of two and at least 2.
REQ-003 The block SHALL have the following ports, clock and reset first:
 clk  in  1  single clock; all state changes on its rising edge
 rst_n  in  1  asynchronous, active-low reset
 if_pc  in  XLEN  fetch-stage PC, used for prediction lookup
 pred_taken  out  1  prediction for if_pc
 id_valid  in  1  decode-stage instruction valid
 id_pc  in  XLEN  decode-stage PC
 id_instr  in  32  decode-stage instruction
 id_pred_taken  in  1  prediction carried with id_instr
 rf_rs1  in  XLEN  register-file rs1 read data
 rf_rs2  in  XLEN  register-file rs2 read data
 ex_rd  in  5  EX destination register
 ex_wr  in  1  EX writes ex_rd
 ex_is_load  in  1  EX instruction is a load
 ex_result  in  XLEN  ALU output
 mem_rd  in  5  MEM destination register
 mem_wr  in  1  MEM writes mem_rd
 mem_result  in  XLEN  MEM writeback value
 stall  out  1  hold IF/ID one cycle
 redirect  out  1  flush IF, fetch redirect_pc
 redirect_pc  out  XLEN  corrected fetch PC

Function
REQ-004 The block SHALL decode opcode 1100011 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111), JAL 1101111 and JALR 1100111; other opcodes and undefined funct3 values are not branches.
REQ-005 Operand forwarding SHALL apply priority EX (ex_wr, ex_rd == rs, rs != 0) over MEM (mem_wr, mem_rd == rs, rs != 0) over the register file.
REQ-006 stall SHALL be 1 when id_valid is 1, a branch or JALR is present, ex_is_load and ex_wr are 1, ex_rd != 0, and ex_rd matches a used rs; JAL never stalls.
REQ-007 While stall is 1, redirect SHALL be 0 and the BHT SHALL NOT update.
REQ-008 Comparisons SHALL be signed for BLT/BGE and unsigned for BLTU/BGEU, across the full XLEN width.
REQ-009 Targets: branch and JAL SHALL use id_pc + imm; JALR SHALL use (rs1 + imm) with bit 0 cleared; the fall-through address SHALL be id_pc + 4; all arithmetic is modulo 2^XLEN.
REQ-010 redirect SHALL be combinational in the same cycle and SHALL assert when id_valid is 1, not squashed, not stalled, and any of the following holds:
 - the instruction is JAL or JALR;
 - it is a conditional branch whose outcome differs from id_pred_taken.
REQ-011 redirect_pc SHALL be the target when the branch is taken and the fall-through address when it is not; it is 0 when redirect is 0.
REQ-012 The squash flag SHALL be set for exactly the cycle after redirect is 1; while it is set, the decode instruction is treated as invalid (no redirect, stall or update).
REQ-013 The BHT index SHALL be pc[log2(BHT_ENTRIES)+1:2].
REQ-014 pred_taken SHALL be the counter MSB for if_pc, read combinationally.
REQ-015 On each resolved conditional branch, the BHT counter SHALL increment if taken and decrement if not, saturating at 2'b11 and 2'b00.
REQ-016 A lookup and an update to the same index in the same cycle SHALL return the pre-update value, with no bypass.

Reset
REQ-017 rst_n low SHALL immediately set every BHT counter to 2'b01 (weakly not-taken), clear the squash flag, and clear the statistics counters.
REQ-018 While rst_n is low, pred_taken SHALL be 0; stall, redirect and redirect_pc are 0 while the decode inputs are idle.
REQ-019 Reset asserted mid-operation SHALL discard any pending squash.

Configuration
REQ-020 With BRANCH_STATS_EN defined, the block SHALL add 32-bit outputs br_count and mispred_count.
 - br_count increments on each resolved conditional branch.
 - mispred_count increments on each conditional-branch redirect.
 - Both wrap at 2^32.
REQ-021 Without BRANCH_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-022 After reset, issue BEQ x1,x2 with rf values 5/5, id_pred_taken=0, id_pc=0x100, imm=+16 -> redirect=1, redirect_pc=0x110; next cycle squash is set and no redirect occurs.
REQ-023 Resolve a taken branch at PC 0x40 three times -> counter 01->10->11->11, and pred_taken=1 for if_pc=0x40.
REQ-024 With EX a load, ex_rd=x3, and BNE x3,x0 in decode -> stall=1 and no redirect; the next cycle, with the load in MEM and mem_result=0, the branch resolves not-taken.
REQ-025 BLT with rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken.
REQ-026 JALR with rs1=0x203, imm=0 and ex_rd=rs1 with ex_result=0x305 -> redirect_pc=0x304.
REQ-027 With BRANCH_STATS_EN, 4 conditional branches of which 1 is mispredicted -> br_count=4, mispred_count=1.
